// File: rtl/pc_fetch_unit.sv
// RV32 program-counter / instruction-fetch stage: one instruction in flight,
// fetch over a req/ready handshake, next-PC selection and misaligned-target trap.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        trap_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_trap,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_target
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [31:0] trap_target_q, trap_target_d;
    logic [31:0] next_pc;
    logic [31:0] jalr_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_VECTOR;
            instr_q       <= NOP;
            trap_pc_q     <= 32'h0;
            trap_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            trap_pc_q     <= trap_pc_d;
            trap_target_q <= trap_target_d;
        end
    end

    // JALR outranks JAL, which outranks a taken branch; bit 0 of a JALR target is dropped.
    always_comb begin
        jalr_sum = rs1_val + imm;
        if (jalr) begin
            next_pc = jalr_sum & ~32'h1;
        end else if (jal || (branch && branch_taken)) begin
            next_pc = pc_q + imm;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        trap_pc_d     = trap_pc_q;
        trap_target_d = trap_target_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (retire && !stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        trap_pc_d     = pc_q;
                        trap_target_d = next_pc;
                        state_d       = TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // The request is masked during reset so an abandoned fetch drops at once.
    always_comb begin
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        misalign_trap = 1'b0;
        case (state_q)
            FETCH:   imem_req      = !rst;
            EXEC:    instr_valid   = 1'b1;
            TRAP:    misalign_trap = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign trap_pc     = trap_pc_q;
    assign trap_target = trap_target_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a driver issues instructions and queues the
// expected (pc, instr) and trap records; a monitor pops and compares them.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] TV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire, stall, branch, branch_taken, jal, jalr;
    logic [31:0] imm, rs1_val;
    logic        trap_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc, pc_plus4;
    logic        misalign_trap;
    logic [31:0] trap_pc, trap_target;

    pc_fetch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .retire(retire), .stall(stall), .branch(branch),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr), .imm(imm),
        .rs1_val(rs1_val), .trap_ack(trap_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misalign_trap(misalign_trap), .trap_pc(trap_pc), .trap_target(trap_target)
    );

    always #5 clk = ~clk;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] trap_q[$];
    logic [31:0] m_pc;
    logic        prev_valid = 1'b0;
    logic        prev_trap  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Reference next-PC: the priority list applied with plain modulo-2^32 adds.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic br, tk, jl, jr,
                                             input logic [31:0] im, r1);
        logic [31:0] t;
        if (jr) begin
            t = r1 + im;
            t[0] = 1'b0;
            return t;
        end
        if (jl || (br && tk)) return cur + im;
        return cur + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act !== req) $display("FAIL %s: actual=%h required=%h", name, act, req);
        else pass_cnt++;
    endtask

    task automatic note_fail(input string name);
        chk_cnt++;
        $display("FAIL %s: actual=output-with-empty-queue required=queued-expectation", name);
    endtask

    // Monitor: compare on each entry to EXEC and each entry to TRAP.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_trap  <= 1'b0;
        end else begin
            if (instr_valid && !prev_valid) begin
                if (exp_q.size() == 0) note_fail("exec_unexpected");
                else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("mon_pc", pc, e[63:32]);
                    check("mon_instr", instr, e[31:0]);
                    check("mon_pc_plus4", pc_plus4, e[63:32] + 32'd4);
                end
            end
            if (misalign_trap && !prev_trap) begin
                if (trap_q.size() == 0) note_fail("trap_unexpected");
                else begin
                    logic [63:0] t;
                    t = trap_q.pop_front();
                    check("mon_trap_pc", trap_pc, t[63:32]);
                    check("mon_trap_target", trap_target, t[31:0]);
                    check("mon_trap_pc_hold", pc, t[63:32]);
                    check("mon_trap_valid", 32'(instr_valid), 32'd0);
                end
            end
            prev_valid <= instr_valid;
            prev_trap  <= misalign_trap;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_ctrl();
        {branch, branch_taken, jal, jalr} = 4'($urandom);
        imm     = $urandom;
        rs1_val = $urandom;
    endtask

    task automatic fetch_phase(input int ws, input bit use_fixed, input logic [31:0] fixed);
        exp_q.push_back({m_pc, use_fixed ? fixed : mem_word(m_pc)});
        for (int w = 0; w < ws; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            trap_ack   = 1'($urandom);
            {stall, retire} = 2'($urandom);
            garbage_ctrl();
            @(negedge clk);
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", imem_addr, m_pc);
            cyc();
        end
        imem_ready = 1'b1;
        imem_rdata = use_fixed ? fixed : mem_word(imem_addr);
        trap_ack   = 1'($urandom);
        @(negedge clk);
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        cyc();
        imem_ready = 1'b0;
        trap_ack   = 1'b0;
    endtask

    task automatic exec_phase(input int hold, input bit force_stall, input logic br, tk, jl, jr,
                              input logic [31:0] im, r1, input int tw);
        logic [31:0] nxt;
        for (int h = 0; h < hold; h++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            trap_ack   = 1'($urandom);
            garbage_ctrl();
            if (force_stall) begin
                stall = 1'b1; retire = 1'b1;
            end else if ($urandom % 2 == 0) begin
                stall = 1'b1; retire = 1'($urandom);
            end else begin
                stall = 1'b0; retire = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", pc, m_pc);
            cyc();
        end
        {branch, branch_taken, jal, jalr} = {br, tk, jl, jr};
        imm = im; rs1_val = r1;
        stall = 1'b0; retire = 1'b1;
        imem_ready = 1'($urandom);
        trap_ack   = 1'($urandom);
        nxt = ref_next(m_pc, br, tk, jl, jr, im, r1);
        if (nxt[1:0] != 2'b00) trap_q.push_back({m_pc, nxt});
        @(negedge clk);
        check("retire_valid", 32'(instr_valid), 32'd1);
        cyc();
        retire = 1'b0; imem_ready = 1'b0; trap_ack = 1'b0;
        garbage_ctrl();
        if (nxt[1:0] != 2'b00) begin
            for (int t = 0; t < tw; t++) begin
                trap_ack = 1'b0;
                {stall, retire} = 2'($urandom);
                @(negedge clk);
                check("trap_flag", 32'(misalign_trap), 32'd1);
                check("trap_pc_hold", pc, m_pc);
                cyc();
            end
            trap_ack = 1'b1;
            @(negedge clk);
            check("trap_flag", 32'(misalign_trap), 32'd1);
            cyc();
            trap_ack = 1'b0; stall = 1'b0; retire = 1'b0;
            m_pc = TV;
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic instr_plain(input int ws, input int hold);
        fetch_phase(ws, 1'b0, 32'h0);
        exec_phase(hold, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    endtask

    task automatic jump_to(input logic [31:0] target);
        fetch_phase(0, 1'b0, 32'h0);
        exec_phase(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, target, 0);
    endtask

    initial begin
        rst = 1'b1;
        {retire, stall, branch, branch_taken, jal, jalr, trap_ack, imem_ready} = '0;
        imm = '0; rs1_val = '0; imem_rdata = '0;
        m_pc = RV;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, RV);
        check("rst_instr", instr, NOP);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_trap", 32'(misalign_trap), 32'd0);
        check("rst_trap_pc", trap_pc, 32'h0);
        check("rst_trap_target", trap_target, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) instr_plain(0, 0);

        fetch_phase(3, 1'b1, 32'h00A0_0093);
        exec_phase(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);

        jump_to(32'h40);
        fetch_phase(0, 1'b0, 32'h0);
        exec_phase(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 0);
        check("branch_taken_pc", m_pc, 32'h30);
        jump_to(32'h40);
        fetch_phase(0, 1'b0, 32'h0);
        exec_phase(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 0);
        jump_to(32'h40);
        fetch_phase(1, 1'b0, 32'h0);
        exec_phase(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 0);

        fetch_phase(0, 1'b0, 32'h0);
        exec_phase(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h1001, 0);
        instr_plain(0, 0);

        jump_to(32'h20);
        fetch_phase(0, 1'b0, 32'h0);
        exec_phase(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0, 2);
        instr_plain(0, 0);

        jump_to(32'hFFFF_FFFC);
        instr_plain(0, 0);
        instr_plain(0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] r, im;
            logic [3:0]  fl;
            r  = $urandom;
            im = {{20{r[9]}}, r[9:0], 2'b00};
            if ($urandom % 5 == 0) im = im + 32'd2;
            fl = ($urandom % 8 < 3) ? 4'b0000 : 4'($urandom);
            fetch_phase(int'($urandom % 4), 1'b0, 32'h0);
            exec_phase(int'($urandom % 3), 1'b0, fl[3], fl[2], fl[1], fl[0], im,
                       $urandom, int'($urandom % 3));
        end

        // Asynchronous reset in the middle of a fetch.
        jump_to(32'h80);
        imem_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, RV);
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_valid", 32'(instr_valid), 32'd0);
        exp_q.delete();
        trap_q.delete();
        m_pc = RV;
        cyc(); cyc();
        rst = 1'b0;
        instr_plain(2, 0);
        instr_plain(0, 1);

        // Asynchronous reset while an instruction sits in EXEC.
        fetch_phase(0, 1'b0, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_exec_valid", 32'(instr_valid), 32'd0);
        check("async_rst_exec_instr", instr, NOP);
        check("async_rst_exec_pc", pc, RV);
        exp_q.delete();
        trap_q.delete();
        m_pc = RV;
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) instr_plain(1, 0);

        repeat (2) cyc();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("trap_queue_drained", 32'(trap_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
